ir_cmd_ctrl: RTL

IR_CMD_CTRL -- requirements
Module: ir_cmd_ctrl

---
 rtl/ir_cmd_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ir_cmd_ctrl.sv
// IR key-event controller: turns NEC frames and repeat codes into PRESS/HOLD/RELEASE
// events and buffers them in a small FIFO toward a ready/valid consumer.
module ir_cmd_ctrl #(
    parameter int unsigned RELEASE_TIMEOUT = 6_000_000,
    parameter int unsigned HOLD_THRESH     = 3,
    parameter int unsigned HOLD_DIV        = 2,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] ifr_data,
    input  logic       ifr_valid,
    input  logic       repeat_en,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_type,
    output logic [7:0] cmd_data,
    output logic       overflow,
    output logic       key_active
);

    localparam int unsigned TMR_W   = $clog2(RELEASE_TIMEOUT + 1);
    localparam int unsigned CNT_MAX = (HOLD_THRESH > HOLD_DIV) ? HOLD_THRESH : HOLD_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FILL_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] TYPE_PRESS   = 2'b01;
    localparam logic [1:0] TYPE_HOLD    = 2'b10;
    localparam logic [1:0] TYPE_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] typ;
        logic [7:0] data;
    } event_t;

    state_e              state_q, state_d;
    logic   [7:0]        key_q, key_d;
    logic   [TMR_W-1:0]  timer_q, timer_d;
    logic   [CNT_W-1:0]  cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic                rep_q;
    logic                enq_q, enq_d;
    event_t              enq_ev_q, enq_ev_d;
    logic                key_active_q, key_active_d;

    event_t              mem_q [FIFO_DEPTH];
    event_t              mem_d [FIFO_DEPTH];
    logic   [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic   [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic   [FILL_W-1:0] fill_q, fill_d;
    logic                cmd_valid_q, cmd_valid_d;
    event_t              cmd_ev_q, cmd_ev_d;
    logic                overflow_q, overflow_d;

    logic                rep_edge;
    logic                fsm_enq;
    event_t              fsm_ev;
    logic   [CNT_W-1:0]  cnt_next;
    logic                pop;
    logic                push;
    logic                full;

    assign rep_edge = repeat_en & ~rep_q;
    assign cnt_next = cnt_q + CNT_W'(1);

    // Key state machine; a pending PRESS after a key change owns the enqueue slot that cycle
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        pend_d   = 1'b0;
        fsm_enq  = 1'b0;
        fsm_ev   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (ifr_valid) begin
                    fsm_enq = 1'b1;
                    fsm_ev  = '{typ: TYPE_PRESS, data: ifr_data};
                    key_d   = ifr_data;
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = S_PRESSED;
                end
            end
            S_PRESSED, S_HELD: begin
                if (ifr_valid) begin
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = S_PRESSED;
                    if (ifr_data != key_q) begin
                        fsm_enq = 1'b1;
                        fsm_ev  = '{typ: TYPE_RELEASE, data: key_q};
                        key_d   = ifr_data;
                        pend_d  = 1'b1;
                    end
                end else if (rep_edge) begin
                    timer_d = '0;
                    if ((state_q == S_PRESSED) && (cnt_next == CNT_W'(HOLD_THRESH))) begin
                        fsm_enq = 1'b1;
                        fsm_ev  = '{typ: TYPE_HOLD, data: key_q};
                        cnt_d   = '0;
                        state_d = S_HELD;
                    end else if ((state_q == S_HELD) && (cnt_next == CNT_W'(HOLD_DIV))) begin
                        fsm_enq = 1'b1;
                        fsm_ev  = '{typ: TYPE_HOLD, data: key_q};
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_next;
                    end
                end else if (timer_q == TMR_W'(RELEASE_TIMEOUT - 1)) begin
                    fsm_enq = 1'b1;
                    fsm_ev  = '{typ: TYPE_RELEASE, data: key_q};
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        enq_d        = pend_q | fsm_enq;
        enq_ev_d     = pend_q ? '{typ: TYPE_PRESS, data: key_q} : fsm_ev;
        key_active_d = (state_d != S_IDLE);
    end

    // Event FIFO with registered head; a full queue still accepts when the head pops
    always_comb begin
        pop        = cmd_valid_q & cmd_ready;
        full       = (fill_q == FILL_W'(FIFO_DEPTH));
        push       = enq_q & (~full | pop);
        overflow_d = enq_q & full & ~pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = enq_ev_q;
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        fill_d = fill_q;
        if (push && !pop) begin
            fill_d = fill_q + FILL_W'(1);
        end else if (!push && pop) begin
            fill_d = fill_q - FILL_W'(1);
        end

        cmd_valid_d = (fill_d != '0);
        if (fill_d == '0) begin
            cmd_ev_d = '0;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            cmd_ev_d = enq_ev_q;
        end else begin
            cmd_ev_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            timer_q      <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            rep_q        <= 1'b0;
            enq_q        <= 1'b0;
            enq_ev_q     <= '0;
            key_active_q <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_ev_q     <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            rep_q        <= repeat_en;
            enq_q        <= enq_d;
            enq_ev_q     <= enq_ev_d;
            key_active_q <= key_active_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_ev_q     <= cmd_ev_d;
            overflow_q   <= overflow_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_type   = cmd_ev_q.typ;
    assign cmd_data   = cmd_ev_q.data;
    assign overflow   = overflow_q;
    assign key_active = key_active_q;

endmodule
